// File: rtl/runway_pkg.sv
// Shared types for the runway scheduler: FSM states, wind encodings and a
// small helper used to size the shared timer.
package runway_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OCC  = 2'd1,
      GAP  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      CALM = 2'b00,
      RTL  = 2'b01,
      LTR  = 2'b10,
      GUST = 2'b11
   } wind_t;

   function automatic int maxInt(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/runway_timer.sv
// Loadable down-counter with a terminal-count flag; saturates at zero
// instead of wrapping so an idle timer stays harmlessly at terminal.
module runway_timer #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_loadValue,
   input  logic         i_enable,
   output logic         o_terminal
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_loadValue;
      end else if (i_enable && (r_count != '0)) begin
         r_count <= r_count - W'(1);
      end
   end

   assign o_terminal = (r_count == '0);

endmodule

// File: rtl/runway_sched.sv
// Single-runway scheduler: round-robin grant between landing and takeoff,
// occupancy watchdog, and a fixed separation gap after every use.
module runway_sched
   import runway_pkg::*;
#(
   parameter int OCC_CYCLES = 16,
   parameter int GAP_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_land,
   input  logic       req_takeoff,
   input  logic [1:0] wind,
   input  logic       done,
   output logic       grant_land,
   output logic       grant_takeoff,
   output logic       busy,
   output logic [1:0] w_out,
   output logic       timeout
);

   localparam int CNT_W = $clog2(maxInt(OCC_CYCLES, GAP_CYCLES) + 1);
   localparam logic [CNT_W-1:0] OCC_LOAD = CNT_W'(OCC_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

   state_t           r_state;
   state_t           w_nextState;
   logic             r_grantLand;
   logic             r_grantTakeoff;
   logic             r_busy;
   logic             r_timeout;
   logic             r_lastLand;
   logic [1:0]       r_wOut;
   logic             w_grantLand;
   logic             w_grantTakeoff;
   logic             w_timeout;
   logic             w_pickLand;
   logic             w_load;
   logic             w_enable;
   logic             w_terminal;
   logic [CNT_W-1:0] w_loadValue;

   // Landing wins when it is alone or when takeoff was served last.
   assign w_pickLand = req_land && (!req_takeoff || !r_lastLand);

   runway_timer #(.W(CNT_W)) u_timer (
      .clk         (clk),
      .reset       (reset),
      .i_load      (w_load),
      .i_loadValue (w_loadValue),
      .i_enable    (w_enable),
      .o_terminal  (w_terminal)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState    = r_state;
      w_grantLand    = r_grantLand;
      w_grantTakeoff = r_grantTakeoff;
      w_timeout      = 1'b0;
      w_load         = 1'b0;
      w_loadValue    = '0;
      w_enable       = 1'b0;
      case (r_state)
         IDLE: begin
            w_grantLand    = 1'b0;
            w_grantTakeoff = 1'b0;
            if ((wind != GUST) && (req_land || req_takeoff)) begin
               w_nextState    = OCC;
               w_grantLand    = w_pickLand;
               w_grantTakeoff = !w_pickLand;
               w_load         = 1'b1;
               w_loadValue    = OCC_LOAD;
            end
         end
         OCC: begin
            // A done arriving on the terminal cycle still counts as a clean exit.
            if (done || w_terminal) begin
               w_nextState    = GAP;
               w_grantLand    = 1'b0;
               w_grantTakeoff = 1'b0;
               w_timeout      = !done;
               w_load         = 1'b1;
               w_loadValue    = GAP_LOAD;
            end else begin
               w_enable = 1'b1;
            end
         end
         GAP: begin
            w_grantLand    = 1'b0;
            w_grantTakeoff = 1'b0;
            if (w_terminal) begin
               w_nextState = IDLE;
            end else begin
               w_enable = 1'b1;
            end
         end
         default: begin
            w_nextState    = IDLE;
            w_grantLand    = 1'b0;
            w_grantTakeoff = 1'b0;
         end
      endcase
   end

   // Wind tracks the sensor only while idle, so the light pattern stays fixed for a whole runway use.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_grantLand    <= 1'b0;
         r_grantTakeoff <= 1'b0;
         r_busy         <= 1'b0;
         r_timeout      <= 1'b0;
         r_wOut         <= CALM;
         r_lastLand     <= 1'b0;
      end else begin
         r_grantLand    <= w_grantLand;
         r_grantTakeoff <= w_grantTakeoff;
         r_busy         <= (w_nextState != IDLE);
         r_timeout      <= w_timeout;
         if (r_state == IDLE) begin
            r_wOut <= wind;
         end
         if ((r_state == IDLE) && (w_nextState == OCC)) begin
            r_lastLand <= w_pickLand;
         end
      end
   end

   assign grant_land    = r_grantLand;
   assign grant_takeoff = r_grantTakeoff;
   assign busy          = r_busy;
   assign w_out         = r_wOut;
   assign timeout       = r_timeout;

endmodule

// File: doc/runway_sched.md
RUNWAY_SCHED -- requirements
Module: runway_sched

Interface
REQ-001 Parameter OCC_CYCLES, default 16: maximum cycles a grant is held without a done before the grant is forcibly revoked.
REQ-002 Parameter GAP_CYCLES, default 4: separation cycles after each runway use, during which no grant is issued.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_land  input  1  landing request, level, held by the requester until granted.
REQ-006 req_takeoff  input  1  takeoff request, level.
REQ-007 wind  input  2  wind sensor: 00 calm, 01 right-to-left, 10 left-to-right, 11 gust (unsafe).
REQ-008 done  input  1  one-cycle pulse: the aircraft has cleared the runway.
REQ-009 grant_land  output  1  runway granted to the landing requester.
REQ-010 grant_takeoff  output  1  runway granted to the takeoff requester.
REQ-011 busy  output  1  high in OCC and GAP.
REQ-012 w_out  output  2  pattern select driven to the runway-light block, same encoding as wind.
REQ-013 timeout  output  1  one-cycle pulse when a grant is revoked for exceeding OCC_CYCLES.

Function
REQ-014 The FSM SHALL have three states, IDLE, OCC and GAP; all outputs SHALL be registered.
REQ-015 In IDLE, if wind != 11 and either request is high, the FSM SHALL enter OCC on the next edge with exactly one grant asserted from that edge (1-cycle latency).
REQ-016 In IDLE with wind == 11, no grant SHALL be issued regardless of requests, and the FSM SHALL remain in IDLE.
REQ-017 When only one request is high, that requester SHALL be granted.
REQ-018 When both requests are high, the grant SHALL go to the requester opposite last_served (round-robin).
REQ-019 last_served SHALL update to the requester granted, at each grant.
REQ-020 In OCC, the grant SHALL remain high until done or timeout; deasserting the request SHALL NOT revoke the grant.
REQ-021 In OCC, an occupancy counter SHALL count from 0; done SHALL move the FSM to GAP on the next edge.
REQ-022 If the counter reaches OCC_CYCLES-1 without done, timeout SHALL pulse for one cycle and the FSM SHALL enter GAP.
REQ-023 If done and the terminal count occur in the same cycle, done SHALL win and timeout SHALL stay low.
REQ-024 In GAP, both grants SHALL be low, requests SHALL be ignored, and the FSM SHALL return to IDLE after exactly GAP_CYCLES cycles.
REQ-025 done SHALL be ignored in IDLE and GAP.
REQ-026 In IDLE, w_out SHALL follow wind registered (1-cycle delay).
REQ-027 In OCC and GAP, w_out SHALL hold the wind value latched at grant; wind changes, including to 11, SHALL have no effect until IDLE.
REQ-028 Counters SHALL be sized $clog2(max(OCC_CYCLES,GAP_CYCLES)+1) bits and SHALL NOT wrap.

Reset
REQ-029 Reset SHALL force state IDLE, both grants 0, busy 0, timeout 0, w_out 00 and counters 0.
REQ-030 Reset SHALL set last_served to takeoff, so that the first contested grant goes to landing.
REQ-031 Reset asserted mid-OCC SHALL drop the grant immediately (asynchronously), with no timeout pulse.

Structure
REQ-032 Package runway_pkg SHALL hold the state enum (IDLE, OCC, GAP) and the wind encodings (CALM, RTL, LTR, GUST).
REQ-033 One sub-module, runway_timer (a loadable down-counter with a terminal-count flag), SHALL be used for both the occupancy count and the gap count.

Verification
REQ-034 Reset, then req_land=1 with wind=01 -> grant_land=1 one cycle later, busy=1, w_out=01; done pulse -> grant_land=0, then 4 GAP cycles, then IDLE.
REQ-035 Both requests high continuously from reset -> grants alternate land, takeoff, land, with 4-cycle gaps between them.
REQ-036 req_takeoff=1, no done for 16 cycles -> timeout pulses once, grant drops, GAP follows; done on cycle 16 instead -> timeout stays 0.
REQ-037 wind=11 with req_land=1 -> no grant; wind changes to 00 -> grant one cycle later; wind changes to 11 during OCC -> grant held and w_out unchanged.
REQ-038 Reset asserted during OCC -> grants 0 at once; after release, req_land and req_takeoff both high -> landing granted first.
